// File: rtl/inst_fetch_resp_pkg.sv
// Shared definitions for the instruction-fetch responder: reset/chip-enable
// levels, bus widths, the NOP word and the FSM state encodings.
package inst_fetch_resp_pkg;

  localparam logic RstEnable   = 1'b0;
  localparam logic RstDisable  = 1'b1;
  localparam logic ChipEnable  = 1'b1;
  localparam logic ChipDisable = 1'b0;

  localparam int InstAddrBus = 32;
  localparam int InstBus     = 32;

  localparam logic [InstBus-1:0] ZeroWord = 32'h0000_0000;

  typedef enum logic [1:0] {
    IfrIdle = 2'b00,
    IfrWait = 2'b01,
    IfrResp = 2'b10
  } ifr_state_e;

endpackage

// File: rtl/inst_fetch_resp_mem.sv
// inst_mem_array: word array with one synchronous read port and one
// synchronous write port. A read and a write to the same index on the same
// edge return the old word. The array itself is never reset; only the read
// register is, so an idle responder presents ZeroWord.
module inst_mem_array
  import inst_fetch_resp_pkg::*;
#(
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we_i,
  input  logic [DEPTH_LOG2-1:0] wr_idx_i,
  input  logic [InstBus-1:0]    wr_data_i,
  input  logic                  re_i,
  input  logic [DEPTH_LOG2-1:0] rd_idx_i,
  output logic [InstBus-1:0]    rd_data_o
);

  logic [InstBus-1:0] r_mem [0:(1<<DEPTH_LOG2)-1];

  // Write port: contents are left unreset so the array maps to plain RAM.
  always_ff @(posedge clk) begin
    if (we_i) begin
      r_mem[wr_idx_i] <= wr_data_i;
    end
  end

  // Read register: holds the last captured word until the next read.
  always_ff @(posedge clk or negedge rst) begin
    if (rst == RstEnable) begin
      rd_data_o <= ZeroWord;
    end else if (re_i) begin
      rd_data_o <= r_mem[rd_idx_i];
    end
  end

endmodule

// File: rtl/inst_fetch_resp.sv
// inst_fetch_resp: memory side of the CPU instruction-fetch interface.
// Serves words after WAIT_CYCLES wait states and raises stallreq_o until the
// word for the presented address is available.
// Optional feature macro: INST_ALIGN_CHECK_EN adds err_o and rejects
// misaligned fetches without waiting.
//
// state   | meaning
// IfrIdle | no fetch outstanding
// IfrWait | counting wait states for addr_q
// IfrResp | data_q holds the word for addr_q
module inst_fetch_resp
  import inst_fetch_resp_pkg::*;
#(
  parameter int DEPTH_LOG2  = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ce_i,
  input  logic [InstAddrBus-1:0] addr_i,
  output logic [InstBus-1:0]     inst_o,
  output logic                   stallreq_o,
`ifdef INST_ALIGN_CHECK_EN
  output logic                   err_o,
`endif
  input  logic                   ld_we_i,
  input  logic [InstAddrBus-1:0] ld_addr_i,
  input  logic [InstBus-1:0]     ld_data_i
);

  localparam logic [3:0] WaitLd = 4'(WAIT_CYCLES);

  ifr_state_e             r_state_q, w_state_d;
  logic [InstAddrBus-1:0] r_addr_q, w_addr_d;
  logic [3:0]             r_cnt_q, w_cnt_d;
  logic                   w_rd_en;
  logic [DEPTH_LOG2-1:0]  w_rd_idx;
  logic [InstBus-1:0]     w_data_q;
  logic                   w_hit;
  logic                   w_mis;
  logic                   w_unused_ld;

  assign w_unused_ld = ^{ld_addr_i[InstAddrBus-1:DEPTH_LOG2+2], ld_addr_i[1:0]};

  inst_mem_array #(
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_mem (
    .clk       (clk),
    .rst       (rst),
    .we_i      (ld_we_i),
    .wr_idx_i  (ld_addr_i[DEPTH_LOG2+1:2]),
    .wr_data_i (ld_data_i),
    .re_i      (w_rd_en),
    .rd_idx_i  (w_rd_idx),
    .rd_data_o (w_data_q)
  );

`ifdef INST_ALIGN_CHECK_EN
  logic                   r_mis_seen;
  logic [InstAddrBus-1:0] r_mis_addr;

  assign w_mis = (ce_i == ChipEnable) && (addr_i[1:0] != 2'b00);

  // Remember the last misaligned address so err_o pulses once per address.
  always_ff @(posedge clk or negedge rst) begin
    if (rst == RstEnable) begin
      r_mis_seen <= 1'b0;
      r_mis_addr <= '0;
    end else begin
      r_mis_seen <= w_mis;
      if (w_mis) begin
        r_mis_addr <= addr_i;
      end
    end
  end

  assign err_o = w_mis && !(r_mis_seen && (addr_i == r_mis_addr));
`else
  assign w_mis = 1'b0;
`endif

  // A response is only valid for the exact address that was fetched.
  assign w_hit = (r_state_q == IfrResp) && (addr_i == r_addr_q);

  // State, latched address and wait counter.
  always_ff @(posedge clk or negedge rst) begin
    if (rst == RstEnable) begin
      r_state_q <= IfrIdle;
      r_addr_q  <= '0;
      r_cnt_q   <= '0;
    end else begin
      r_state_q <= w_state_d;
      r_addr_q  <= w_addr_d;
      r_cnt_q   <= w_cnt_d;
    end
  end

  // Next-state logic. A new or changed address always restarts the fetch,
  // which also covers a redirect while waiting. The array is read on the
  // edge where the counter runs out, so the word appears exactly
  // WAIT_CYCLES+1 cycles after the address is first presented.
  always_comb begin
    w_state_d = r_state_q;
    w_addr_d  = r_addr_q;
    w_cnt_d   = r_cnt_q;
    w_rd_en   = 1'b0;
    w_rd_idx  = r_addr_q[DEPTH_LOG2+1:2];
    if ((ce_i != ChipEnable) || w_mis) begin
      w_state_d = IfrIdle;
      w_cnt_d   = '0;
    end else if ((r_state_q == IfrIdle) || (addr_i != r_addr_q)) begin
      w_addr_d = addr_i;
      if (WAIT_CYCLES == 0) begin
        w_rd_en   = 1'b1;
        w_rd_idx  = addr_i[DEPTH_LOG2+1:2];
        w_cnt_d   = '0;
        w_state_d = IfrResp;
      end else begin
        w_cnt_d   = WaitLd;
        w_state_d = IfrWait;
      end
    end else if (r_state_q == IfrWait) begin
      if (r_cnt_q <= 4'd1) begin
        w_cnt_d   = '0;
        w_rd_en   = 1'b1;
        w_state_d = IfrResp;
      end else begin
        w_cnt_d = r_cnt_q - 4'd1;
      end
    end
  end

  assign stallreq_o = (ce_i == ChipEnable) && !w_hit && !w_mis;
  assign inst_o     = ((ce_i == ChipEnable) && w_hit && !w_mis) ? w_data_q : ZeroWord;

endmodule

// File: tb/tb_inst_fetch_resp.sv
// Scoreboard bench for inst_fetch_resp: dut_a uses WAIT_CYCLES=2, dut_b uses
// WAIT_CYCLES=0. Stimulus pushes the expected word and stall count for each
// fetch; a monitor per DUT pops and compares when the stall drops.
module tb_inst_fetch_resp;
  import inst_fetch_resp_pkg::*;

  typedef struct {
    logic [31:0] inst;
    int          stalls;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        ce_a, ce_b;
  logic [31:0] addr_a, addr_b;
  logic [31:0] inst_a, inst_b;
  logic        stall_a, stall_b;
  logic        ld_we;
  logic [31:0] ld_addr, ld_data;
  logic        skip_hold = 1'b0;
`ifdef INST_ALIGN_CHECK_EN
  logic        err_a, err_b;
`endif

  exp_t q_a[$];
  exp_t q_b[$];
  int   n_pass  = 0;
  int   n_total = 0;

  always #5 clk = ~clk;

  inst_fetch_resp #(.DEPTH_LOG2(10), .WAIT_CYCLES(2)) dut_a (
    .clk        (clk),
    .rst        (rst),
    .ce_i       (ce_a),
    .addr_i     (addr_a),
    .inst_o     (inst_a),
    .stallreq_o (stall_a),
`ifdef INST_ALIGN_CHECK_EN
    .err_o      (err_a),
`endif
    .ld_we_i    (ld_we),
    .ld_addr_i  (ld_addr),
    .ld_data_i  (ld_data)
  );

  inst_fetch_resp #(.DEPTH_LOG2(10), .WAIT_CYCLES(0)) dut_b (
    .clk        (clk),
    .rst        (rst),
    .ce_i       (ce_b),
    .addr_i     (addr_b),
    .inst_o     (inst_b),
    .stallreq_o (stall_b),
`ifdef INST_ALIGN_CHECK_EN
    .err_o      (err_b),
`endif
    .ld_we_i    (ld_we),
    .ld_addr_i  (ld_addr),
    .ld_data_i  (ld_data)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
  endtask

  task automatic load(input logic [31:0] a, input logic [31:0] d);
    ld_we   = 1'b1;
    ld_addr = a;
    ld_data = d;
    @(posedge clk); #1;
    ld_we   = 1'b0;
  endtask

  // Present addr from the start of a cycle; hold data for 'hold' cycles.
  task automatic fetch_a(input logic [31:0] a, input logic [31:0] e, input int stalls, input int hold);
    ce_a   = 1'b1;
    addr_a = a;
    q_a.push_back('{inst: e, stalls: stalls});
    repeat (stalls + hold) @(posedge clk);
    #1;
  endtask

  task automatic fetch_b(input logic [31:0] a, input logic [31:0] e, input int stalls, input int hold);
    ce_b   = 1'b1;
    addr_b = a;
    q_b.push_back('{inst: e, stalls: stalls});
    repeat (stalls + hold) @(posedge clk);
    #1;
  endtask

  // Monitor for dut_a.
  initial begin
    int          run;
    logic [31:0] last;
    exp_t        e;
    run  = 0;
    last = 32'h0;
    forever begin
      @(negedge clk);
      if (rst !== 1'b1 || ce_a !== 1'b1) begin
        run = 0;
      end else if (stall_a) begin
        run++;
        chk("a_inst_during_stall", inst_a, 32'h0);
        if (run == 50) chk("a_stall_timeout", run, 0);
      end else if (run > 0) begin
        if (q_a.size() == 0) begin
          chk("a_unexpected_resp", q_a.size(), 1);
        end else begin
          e = q_a.pop_front();
          chk("a_inst", inst_a, e.inst);
          chk("a_stall_cycles", run, e.stalls);
          last = e.inst;
        end
        run = 0;
      end else if (!skip_hold) begin
        chk("a_hold", inst_a, last);
      end
    end
  end

  // Monitor for dut_b.
  initial begin
    int          run;
    logic [31:0] last;
    exp_t        e;
    run  = 0;
    last = 32'h0;
    forever begin
      @(negedge clk);
      if (rst !== 1'b1 || ce_b !== 1'b1) begin
        run = 0;
      end else if (stall_b) begin
        run++;
        chk("b_inst_during_stall", inst_b, 32'h0);
        if (run == 50) chk("b_stall_timeout", run, 0);
      end else if (run > 0) begin
        if (q_b.size() == 0) begin
          chk("b_unexpected_resp", q_b.size(), 1);
        end else begin
          e = q_b.pop_front();
          chk("b_inst", inst_b, e.inst);
          chk("b_stall_cycles", run, e.stalls);
          last = e.inst;
        end
        run = 0;
      end else begin
        chk("b_hold", inst_b, last);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst     = 1'b0;
    ce_a    = 1'b0;
    ce_b    = 1'b0;
    addr_a  = 32'h0;
    addr_b  = 32'h0;
    ld_we   = 1'b0;
    ld_addr = 32'h0;
    ld_data = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_inst_a", inst_a, 32'h0);
    chk("rst_stall_a", {31'h0, stall_a}, 32'h0);
    chk("rst_inst_b", inst_b, 32'h0);
    chk("rst_stall_b", {31'h0, stall_b}, 32'h0);
    chk("rst_state_a", 32'(dut_a.r_state_q), 32'(IfrIdle));
    chk("rst_addr_q_a", dut_a.r_addr_q, 32'h0);
    chk("rst_cnt_a", 32'(dut_a.r_cnt_q), 32'h0);
    ce_a = 1'b1;
    #1;
    chk("rst_stall_follows_ce", {31'h0, stall_a}, 32'h1);
    chk("rst_inst_ce", inst_a, 32'h0);
    ce_a = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;

    load(32'h0000_0000, 32'h3401_1100);
    load(32'h0000_0004, 32'h3402_0020);
    load(32'h0000_0008, 32'h0000_0000);
    load(32'h0000_000C, 32'h3403_0040);
    load(32'h0000_0010, 32'h2410_0010);
    load(32'h0000_0040, 32'h2440_0040);
    load(32'h0000_0020, 32'h1111_1111);

    // Sequential fetches, each paying full latency.
    fetch_a(32'h0, 32'h3401_1100, 3, 2);
    fetch_a(32'h4, 32'h3402_0020, 3, 2);
    ce_a = 1'b0;
    @(posedge clk); #1;

    // Redirect on the second cycle: only mem[0x40] may appear.
    ce_a   = 1'b1;
    addr_a = 32'h10;
    q_a.push_back('{inst: 32'h2440_0040, stalls: 4});
    @(posedge clk); #1;
    addr_a = 32'h40;
    repeat (5) @(posedge clk);
    #1;
    ce_a = 1'b0;
    @(posedge clk); #1;

    // Load write during WAIT is seen; write after capture is not.
    ce_a   = 1'b1;
    addr_a = 32'h20;
    q_a.push_back('{inst: 32'h2222_2222, stalls: 3});
    @(posedge clk); #1;
    load(32'h20, 32'h2222_2222);
    @(posedge clk); #1;
    load(32'h20, 32'h3333_3333);
    repeat (2) @(posedge clk);
    #1;

    // Address wrap-around.
    ce_a = 1'b0;
    load(32'h0, 32'hDEAD_BEEF);
    fetch_a(32'h1000, 32'hDEAD_BEEF, 3, 2);
    ce_a = 1'b0;
    @(posedge clk); #1;

    // Asynchronous reset during WAIT drops the fetch.
    ce_a   = 1'b1;
    addr_a = 32'h4;
    @(posedge clk); #1;
    chk("pre_rst_state_wait", 32'(dut_a.r_state_q), 32'(IfrWait));
    rst = 1'b0;
    #1;
    chk("midrst_inst", inst_a, 32'h0);
    chk("midrst_state", 32'(dut_a.r_state_q), 32'(IfrIdle));
    ce_a = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    fetch_a(32'h4, 32'h3402_0020, 3, 2);
    ce_a = 1'b0;
    @(posedge clk); #1;

    // Zero wait states: one stall cycle per new address.
    fetch_b(32'h8, 32'h0000_0000, 1, 2);
    fetch_b(32'hC, 32'h3403_0040, 1, 2);
    ce_b = 1'b0;
    @(posedge clk); #1;

`ifdef INST_ALIGN_CHECK_EN
    skip_hold = 1'b1;
    ce_a      = 1'b1;
    addr_a    = 32'h6;
    #1;
    chk("mis_err_first", {31'h0, err_a}, 32'h1);
    chk("mis_stall", {31'h0, stall_a}, 32'h0);
    chk("mis_inst", inst_a, 32'h0);
    @(posedge clk); #1;
    chk("mis_err_second", {31'h0, err_a}, 32'h0);
    skip_hold = 1'b0;
    fetch_a(32'h4, 32'h3402_0020, 3, 2);
    ce_a = 1'b0;
    @(posedge clk); #1;
`endif

    repeat (2) @(posedge clk);
    #1;
    chk("queue_a_empty", q_a.size(), 0);
    chk("queue_b_empty", q_b.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
